// File: rtl/arm_pkg.sv
// Shared ARM branch-resolution types: branch kinds, condition codes, flag bit positions, FSM states.
package arm_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_CBZ  = 2'b10,
    BR_COND = 2'b11
  } br_type_e;

  typedef enum logic [3:0] {
    C_EQ = 4'b0000,
    C_NE = 4'b0001,
    C_HS = 4'b0010,
    C_LO = 4'b0011,
    C_MI = 4'b0100,
    C_PL = 4'b0101,
    C_VS = 4'b0110,
    C_VC = 4'b0111,
    C_HI = 4'b1000,
    C_LS = 4'b1001,
    C_GE = 4'b1010,
    C_LT = 4'b1011,
    C_GT = 4'b1100,
    C_LE = 4'b1101,
    C_AL = 4'b1110,
    C_NV = 4'b1111
  } cond_e;

  // Flag register layout is {N,Z,V,C}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam int CNT_W = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_cond_unit_if.sv
// Request/response bundle between the branch unit and the datapath.
// Handshake: a request transfers on a rising edge where in_valid & in_ready; the
// requester holds every request field stable while in_valid=1 and in_ready=0.
// out_valid is a one-cycle pulse with no backpressure; taken is qualified by it.
interface branch_cond_unit_if
  import arm_pkg::*;
#(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  br_type_e         br_type;
  cond_e            cond;
  logic [WIDTH-1:0] cbz_val;
  logic [3:0]       stored_flags;
  logic [3:0]       fwd_flags;
  logic             fwd_valid;
  logic             out_valid;
  logic             taken;
  logic             flush;

  modport master (
    output in_valid, br_type, cond, cbz_val, stored_flags, fwd_flags, fwd_valid,
    input  in_ready, out_valid, taken, flush
  );

  modport slave (
    input  in_valid, br_type, cond, cbz_val, stored_flags, fwd_flags, fwd_valid,
    output in_ready, out_valid, taken, flush
  );
endinterface

// File: rtl/branch_cond_unit_cond_eval.sv
// Pure combinational ARMv8 condition-code evaluator over a {N,Z,V,C} flag nibble.
module cond_eval
  import arm_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, v, c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  always_comb begin
    pass = 1'b0;
    case (cond)
      C_EQ: pass = z;
      C_NE: pass = ~z;
      C_HS: pass = c;
      C_LO: pass = ~c;
      C_MI: pass = n;
      C_PL: pass = ~n;
      C_VS: pass = v;
      C_VC: pass = ~v;
      C_HI: pass = c & ~z;
      C_LS: pass = ~c | z;
      C_GE: pass = (n == v);
      C_LT: pass = (n != v);
      C_GT: pass = ~z & (n == v);
      C_LE: pass = z | (n != v);
      // NV behaves as always in AArch64.
      C_AL: pass = 1'b1;
      C_NV: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_cond_unit.sv
// Branch decision unit: flag forwarding, CBZ/B/B.cond resolution, registered decision
// and a fixed-length flush window after every taken branch.
module branch_cond_unit
  import arm_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic   clk,
  input  logic   reset_n,
  branch_cond_unit_if.slave bus,
  output state_e state_dbg
);
  state_e           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             out_valid_q;
  logic             taken_q;
  logic [3:0]       sel_flags;
  logic             cond_pass;
  logic             cbz_zero;
  logic             taken_c;
  logic             xfer;

  // Same-cycle flag writes bypass the register so back-to-back cmp/b.cond resolves correctly.
  assign sel_flags = bus.fwd_valid ? bus.fwd_flags : bus.stored_flags;
  assign cbz_zero  = (bus.cbz_val == '0);

  cond_eval u_cond_eval (
    .cond  (bus.cond),
    .flags (sel_flags),
    .pass  (cond_pass)
  );

  always_comb begin
    taken_c = 1'b0;
    case (bus.br_type)
      BR_NONE: taken_c = 1'b0;
      BR_B:    taken_c = 1'b1;
      BR_CBZ:  taken_c = cbz_zero;
      BR_COND: taken_c = cond_pass;
      default: taken_c = 1'b0;
    endcase
  end

  assign bus.in_ready = (state_q == S_IDLE);
  assign xfer         = bus.in_valid & bus.in_ready;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (xfer && taken_c) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      out_valid_q <= xfer;
      if (xfer) begin
        taken_q <= taken_c;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.taken     = taken_q;
  assign bus.flush     = (state_q == S_FLUSH);
  assign state_dbg     = state_q;
endmodule
